// File: rtl/mesi_bus_if.sv
// mesi_bus_if: request / snoop / bus-command bundle between the per-core L1
// controllers (master side) and the MESI bus arbiter (slave side).
//   req_valid/req_ins_type/req_hit : per-core access request, type, own hit
//   snoop_found                    : per-core "holds the line" snoop reply
//   req_ready/done                 : one-hot acceptance and completion
//   bus_valid/bus_signals          : {core_id, BusRd, BusRdX, BusUpgr}
//   bus_shared                     : copy flag of the current transaction
interface mesi_bus_if #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 2
);
  logic [N_CORES-1:0] req_valid;
  logic [N_CORES-1:0] req_ins_type;
  logic [N_CORES-1:0] req_hit;
  logic [N_CORES-1:0] snoop_found;
  logic [N_CORES-1:0] req_ready;
  logic [N_CORES-1:0] done;
  logic               bus_valid;
  logic [ID_W+2:0]    bus_signals;
  logic               bus_shared;

  modport master (
    output req_valid, req_ins_type, req_hit, snoop_found,
    input  req_ready, done, bus_valid, bus_signals, bus_shared
  );

  modport slave (
    input  req_valid, req_ins_type, req_hit, snoop_found,
    output req_ready, done, bus_valid, bus_signals, bus_shared
  );
endinterface

// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter: round-robin front end of the shared MESI snooping bus.
// Accepts one L1 request at a time, spends one cycle collecting snoop
// replies from the other cores, issues BusRd/BusRdX/BusUpgr for BUS_LAT
// cycles when needed and pulses done to the requester.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : request/snoop/command bundle (see mesi_bus_if)
//   cnt_busrd/rdx/upgr : saturating counts of issued bus commands
module mesi_bus_arbiter #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 2,
  parameter int BUS_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  mesi_bus_if.slave        bus,
  output logic [CNT_W-1:0] cnt_busrd,
  output logic [CNT_W-1:0] cnt_busrdx,
  output logic [CNT_W-1:0] cnt_busupgr
);

  localparam int LAT_W = (BUS_LAT > 1) ? $clog2(BUS_LAT) : 1;

  typedef enum logic [1:0] {IDLE, SNOOP, BUS, DONE} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_type;
  logic               gnt_hit;
  logic [LAT_W-1:0]   lat_cnt;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_c;
  logic [ID_W-1:0]    scan_id;
  logic [N_CORES-1:0] others;
  logic               copy;
  logic [2:0]         cmd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin search: first pending request at or above rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_c     = '0;
    scan_id   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      scan_id = ID_W'((int'(rr_ptr) + i) % N_CORES);
      if (!gnt_found && bus.req_valid[scan_id]) begin
        gnt_found = 1'b1;
        gnt_c     = scan_id;
      end
    end
  end

  assign bus.req_ready = (!rst && state == IDLE && gnt_found)
                         ? (N_CORES'(1) << gnt_c) : '0;

  // The requester's own snoop reply never counts as another copy.
  always_comb begin
    others = bus.snoop_found & ~(N_CORES'(1) << gnt_id);
    copy   = |others;
    cmd    = 3'b000;
    case ({gnt_type, gnt_hit})
      2'b00:   cmd = copy ? 3'b100 : 3'b000;
      2'b10:   cmd = 3'b010;
      2'b11:   cmd = copy ? 3'b001 : 3'b000;
      default: cmd = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      bus.done        <= '0;
      bus.bus_valid   <= 1'b0;
      bus.bus_signals <= '0;
      bus.bus_shared  <= 1'b0;
      cnt_busrd       <= '0;
      cnt_busrdx      <= '0;
      cnt_busupgr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt_id   <= gnt_c;
            gnt_type <= bus.req_ins_type[gnt_c];
            gnt_hit  <= bus.req_hit[gnt_c];
            state    <= SNOOP;
          end
        end
        // SNOOP -> BUS/DONE: command and shared flag registered here
        SNOOP: begin
          bus.bus_shared <= copy;
          lat_cnt        <= '0;
          if (cmd != 3'b000) begin
            bus.bus_valid   <= 1'b1;
            bus.bus_signals <= {gnt_id, cmd};
            if (cmd[2]) cnt_busrd   <= sat_inc(cnt_busrd);
            if (cmd[1]) cnt_busrdx  <= sat_inc(cnt_busrdx);
            if (cmd[0]) cnt_busupgr <= sat_inc(cnt_busupgr);
            state <= BUS;
          end else begin
            bus.done <= N_CORES'(1) << gnt_id;
            state    <= DONE;
          end
        end
        // BUS -> DONE after BUS_LAT cycles of bus occupancy
        BUS: begin
          if (lat_cnt == LAT_W'(BUS_LAT - 1)) begin
            bus.bus_valid   <= 1'b0;
            bus.bus_signals <= '0;
            bus.done        <= N_CORES'(1) << gnt_id;
            state           <= DONE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        DONE: begin
          bus.done <= '0;
          rr_ptr   <= (gnt_id == ID_W'(N_CORES - 1)) ? '0 : gnt_id + ID_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
